// File: rtl/startup_pkg.sv
// Shared state encoding and default timing constants for the power-up/arming sequencer.
package startup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_INIT   = 3'd2,
    ST_CAL    = 3'd3,
    ST_ARM    = 3'd4,
    ST_READY  = 3'd5,
    ST_FAULT  = 3'd6
  } seq_state_t;

  localparam int SETTLE_CYC_DEF  = 50000;
  localparam int ARM_CYC_DEF     = 5000000;
  localparam int TIMEOUT_CYC_DEF = 10000000;

endpackage

// File: rtl/startup_seq_timer.sv
// Saturating cycle counter with synchronous clear and a terminal-value compare.
module cyc_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  // done is high during the cycle whose count equals terminal
  assign done = (cnt == terminal);

endmodule

// File: rtl/startup_seq.sv
// Power-up/arming sequencer: settle, sensor init, calibration, ESC arming, with kill and sticky fault.
module startup_seq
  import startup_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int ARM_CYC     = ARM_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       sensor_rdy,
  input  logic       cal_done,
  input  logic       kill,
  input  logic       clr_fault,
  output logic       snsr_init,
  output logic       cal_start,
  output logic       esc_min,
  output logic       armed,
  output logic       fault,
  output logic [2:0] state_o
);

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] terminal;
  logic             done;
  logic             leaving;

  // Handshakes: snsr_init/cal_start are single-cycle requests; sensor_rdy/cal_done
  // are sampled each cycle of INIT/CAL and win over a timeout expiring in that cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (go) next_state = ST_SETTLE;
      ST_SETTLE: if (done) next_state = ST_INIT;
      ST_INIT: begin
        if (sensor_rdy)  next_state = ST_CAL;
        else if (done)   next_state = ST_FAULT;
      end
      ST_CAL: begin
        if (cal_done)    next_state = ST_ARM;
        else if (done)   next_state = ST_FAULT;
      end
      ST_ARM:    if (done) next_state = ST_READY;
      ST_READY:  next_state = ST_READY;
      ST_FAULT:  if (clr_fault && !kill) next_state = ST_IDLE;
      default:   next_state = ST_FAULT;
    endcase
    if (kill && state != ST_FAULT) next_state = ST_FAULT;
  end

  // Counter runs 0..N-1 in a state, so the compare value is one less than the dwell.
  always_comb begin
    terminal = {CNT_W{1'b1}};
    case (state)
      ST_SETTLE:      terminal = CNT_W'(SETTLE_CYC - 1);
      ST_INIT,
      ST_CAL:         terminal = CNT_W'(TIMEOUT_CYC - 1);
      ST_ARM:         terminal = CNT_W'(ARM_CYC - 1);
      default:        terminal = {CNT_W{1'b1}};
    endcase
  end

  assign leaving = (next_state != state);

  cyc_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (leaving),
    .terminal (terminal),
    .done     (done)
  );

  // Outputs are registered from next_state so they line up with state_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      snsr_init <= 1'b0;
      cal_start <= 1'b0;
      esc_min   <= 1'b1;
      armed     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= next_state;
      snsr_init <= (next_state == ST_INIT) && (state != ST_INIT);
      cal_start <= (next_state == ST_CAL) && (state != ST_CAL);
      esc_min   <= (next_state != ST_READY);
      armed     <= (next_state == ST_READY);
      fault     <= (next_state == ST_FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_startup_seq.sv
// Directed bench for startup_seq: per-cycle expected outputs go to a queue, a monitor checks them.
module tb_startup_seq;
  import startup_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0, sensor_rdy = 1'b0, cal_done = 1'b0, kill = 1'b0, clr_fault = 1'b0;
  logic       snsr_init, cal_start, esc_min, armed, fault;
  logic [2:0] state_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  startup_seq #(
    .CNT_W(24), .SETTLE_CYC(4), .ARM_CYC(6), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .sensor_rdy(sensor_rdy), .cal_done(cal_done),
    .kill(kill), .clr_fault(clr_fault), .snsr_init(snsr_init), .cal_start(cal_start),
    .esc_min(esc_min), .armed(armed), .fault(fault), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  // Expected output vector for a state: {state, snsr_init, cal_start, esc_min, armed, fault}
  function automatic logic [W-1:0] exp_vec(input seq_state_t st, input logic si, input logic cs);
    logic e, a, f;
    a = (st == ST_READY);
    e = !a;
    f = (st == ST_FAULT);
    return {st, si, cs, e, a, f};
  endfunction

  // driver: inputs set beforehand are sampled at the coming edge
  task automatic tick(input seq_state_t st, input logic si, input logic cs);
    @(posedge clk);
    #1;
    exp_q.push_back(exp_vec(st, si, cs));
  endtask

  task automatic tick_n(input int n, input seq_state_t st);
    for (int i = 0; i < n; i++) tick(st, 1'b0, 1'b0);
  endtask

  task automatic run_to_init();
    go = 1'b1;
    tick(ST_SETTLE, 1'b0, 1'b0);
    go = 1'b0;
    tick_n(3, ST_SETTLE);
    tick(ST_INIT, 1'b1, 1'b0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {state_o, snsr_init, cal_start, esc_min, armed, fault};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL out_vec check#%0d t=%0t: got st=%0d si=%b cs=%b esc=%b arm=%b flt=%b, want st=%0d si=%b cs=%b esc=%b arm=%b flt=%b",
                 checks, $time, act[7:5], act[4], act[3], act[2], act[1], act[0],
                 exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  end

  initial begin
    // reset state
    rst = 1'b1;
    tick(ST_IDLE, 1'b0, 1'b0);
    tick(ST_IDLE, 1'b0, 1'b0);
    rst = 1'b0;
    tick(ST_IDLE, 1'b0, 1'b0);

    // nominal run
    run_to_init();
    tick_n(3, ST_INIT);
    sensor_rdy = 1'b1;
    tick(ST_CAL, 1'b0, 1'b1);
    sensor_rdy = 1'b0;
    tick_n(5, ST_CAL);
    cal_done = 1'b1;
    tick(ST_ARM, 1'b0, 1'b0);
    cal_done = 1'b0;
    tick_n(5, ST_ARM);
    tick_n(3, ST_READY);

    // kill from READY, clr_fault blocked while kill held
    kill = 1'b1;
    tick(ST_FAULT, 1'b0, 1'b0);
    clr_fault = 1'b1;
    tick_n(2, ST_FAULT);
    kill = 1'b0;
    tick(ST_IDLE, 1'b0, 1'b0);
    clr_fault = 1'b0;
    tick(ST_IDLE, 1'b0, 1'b0);

    // sensor timeout: FAULT 10 cycles after INIT entry
    run_to_init();
    tick_n(9, ST_INIT);
    tick_n(2, ST_FAULT);
    clr_fault = 1'b1;
    tick(ST_IDLE, 1'b0, 1'b0);
    clr_fault = 1'b0;

    // sensor_rdy high before INIT, go during CAL, cal_done on the timeout cycle
    sensor_rdy = 1'b1;
    run_to_init();
    tick(ST_CAL, 1'b0, 1'b1);
    sensor_rdy = 1'b0;
    go = 1'b1;
    tick_n(9, ST_CAL);
    go = 1'b0;
    cal_done = 1'b1;
    tick(ST_ARM, 1'b0, 1'b0);
    cal_done = 1'b0;
    tick_n(3, ST_ARM);

    // reset mid-ARM then a fresh full sequence
    rst = 1'b1;
    tick(ST_IDLE, 1'b0, 1'b0);
    rst = 1'b0;
    tick(ST_IDLE, 1'b0, 1'b0);
    run_to_init();
    sensor_rdy = 1'b1;
    tick(ST_CAL, 1'b0, 1'b1);
    sensor_rdy = 1'b0;
    cal_done = 1'b1;
    tick(ST_ARM, 1'b0, 1'b0);
    cal_done = 1'b0;
    tick_n(5, ST_ARM);
    tick_n(2, ST_READY);

    // kill during SETTLE
    rst = 1'b1;
    tick(ST_IDLE, 1'b0, 1'b0);
    rst = 1'b0;
    go = 1'b1;
    tick(ST_SETTLE, 1'b0, 1'b0);
    go = 1'b0;
    kill = 1'b1;
    tick(ST_FAULT, 1'b0, 1'b0);
    kill = 1'b0;
    tick(ST_FAULT, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
